// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the IF-stage program-counter generator.
package pc_gen_pkg;

  localparam int              INST_ADDR_W      = 32;
  localparam logic [31:0]     RESET_VECTOR_DEF = 32'h0000_0000;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic BRANCH       = 1'b1;
  localparam logic NOT_BRANCH   = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  typedef enum logic {
    DIS = 1'b0,
    RUN = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_gen_if.sv
// Control/branch inputs and fetch outputs of pc_gen; slave is the generator, master is ctrl/ID side.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_addr_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               misalign_o;
  logic               branch_pend_o;

  modport slave (
    input  stall, flush, new_pc, branch_flag_i, branch_addr_i,
    output pc, ce, misalign_o, branch_pend_o
  );

  modport master (
    output stall, flush, new_pc, branch_flag_i, branch_addr_i,
    input  pc, ce, misalign_o, branch_pend_o
  );
endinterface

// File: rtl/pc_gen.sv
// IF-stage PC generator: flush > stall > live branch > pending branch > sequential increment.
// One cycle from reset release to first fetch; all outputs registered, a branch seen during stall is held until pc may move.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W       = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
  parameter int                FETCH_BYTES  = 4,
  parameter int                STALL_W      = 6
) (
  input  logic    clk,
  input  logic    rst,
  pc_gen_if.slave bus
);

  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(FETCH_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(FETCH_BYTES - 1);

  pc_state_t         state;
  logic [ADDR_W-1:0] pc_q;
  logic              ce_q;
  logic              misalign_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_tgt_q;

  logic [ADDR_W-1:0] nxt_pc;
  logic              nxt_pend;
  logic [ADDR_W-1:0] nxt_tgt;

  // Only stall[0] steers the pc; the rest of the vector belongs to later stages.
  logic unused_stall;
  assign unused_stall = ^bus.stall;

  always_comb begin
    nxt_pc   = pc_q + STRIDE;
    nxt_pend = pend_q;
    nxt_tgt  = pend_tgt_q;
    if (bus.flush) begin
      nxt_pc   = bus.new_pc;
      nxt_pend = 1'b0;
    end else if (bus.stall[0] == STOP) begin
      nxt_pc = pc_q;
      if (bus.branch_flag_i == BRANCH) begin
        nxt_pend = 1'b1;
        nxt_tgt  = bus.branch_addr_i;
      end
    end else if (bus.branch_flag_i == BRANCH) begin
      nxt_pc   = bus.branch_addr_i;
      nxt_pend = 1'b0;
    end else if (pend_q) begin
      nxt_pc   = pend_tgt_q;
      nxt_pend = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= DIS;
      pc_q       <= RESET_VECTOR;
      ce_q       <= CHIP_DISABLE;
      misalign_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      case (state)
        DIS: begin
          state      <= RUN;
          ce_q       <= CHIP_ENABLE;
          pc_q       <= RESET_VECTOR;
          misalign_q <= |(RESET_VECTOR & ALIGN_MASK);
        end
        RUN: begin
          ce_q       <= CHIP_ENABLE;
          pc_q       <= nxt_pc;
          misalign_q <= |(nxt_pc & ALIGN_MASK);
          pend_q     <= nxt_pend;
          pend_tgt_q <= nxt_tgt;
        end
        default: state <= DIS;
      endcase
    end
  end

  assign bus.pc            = pc_q;
  assign bus.ce            = ce_q;
  assign bus.misalign_o    = misalign_q;
  assign bus.branch_pend_o = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: hand-computed pc/ce/flag values per scenario.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();

  pc_gen #(
    .ADDR_W(32),
    .RESET_VECTOR(32'h0000_0000),
    .FETCH_BYTES(4),
    .STALL_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall         = 6'b0;
    bus.flush         = 1'b0;
    bus.new_pc        = 32'h0;
    bus.branch_flag_i = 1'b0;
    bus.branch_addr_i = 32'h0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] epc, input logic ece,
                            input logic emis, input logic epend);
    checks++;
    if (bus.pc !== epc || bus.ce !== ece || bus.misalign_o !== emis || bus.branch_pend_o !== epend) begin
      errors++;
      $display("FAIL %s: got pc=%08h ce=%b mis=%b pend=%b, want pc=%08h ce=%b mis=%b pend=%b",
               name, bus.pc, bus.ce, bus.misalign_o, bus.branch_pend_o, epc, ece, emis, epend);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("reset_hold_%0d", i), 32'h0, 1'b0, 1'b0, 1'b0);
    end
    // Inputs must be ignored on the DIS->RUN edge.
    bus.flush  = 1'b1;
    bus.new_pc = 32'h0000_0380;
    rst = 1'b1;
    tick();
    expect_out("first_fetch", 32'h0, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_out("seq_4", 32'h4, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("seq_8", 32'h8, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("seq_c", 32'hC, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_branch_unstalled();
    tick(); expect_out("at_10", 32'h10, 1'b1, 1'b0, 1'b0);
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h0000_0100;
    tick(); expect_out("branch_100", 32'h100, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_out("after_branch_104", 32'h104, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_branch_during_stall();
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h0000_0020;
    tick(); expect_out("goto_20", 32'h20, 1'b1, 1'b0, 1'b0);
    bus.stall         = 6'b000011;
    bus.branch_addr_i = 32'h0000_0200;
    tick(); expect_out("stall1_pend", 32'h20, 1'b1, 1'b0, 1'b1);
    bus.branch_flag_i = 1'b0;
    tick(); expect_out("stall2_hold", 32'h20, 1'b1, 1'b0, 1'b1);
    tick(); expect_out("stall3_hold", 32'h20, 1'b1, 1'b0, 1'b1);
    idle_inputs();
    tick(); expect_out("pend_taken_200", 32'h200, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("after_pend_204", 32'h204, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush_priority();
    bus.stall         = 6'b000001;
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h0000_0700;
    tick(); expect_out("pend_700", 32'h204, 1'b1, 1'b0, 1'b1);
    bus.flush         = 1'b1;
    bus.new_pc        = 32'h0000_0380;
    bus.branch_addr_i = 32'h0000_0500;
    tick(); expect_out("flush_380", 32'h380, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_out("after_flush_384", 32'h384, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_live_beats_pending();
    bus.stall         = 6'b000001;
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h0000_0800;
    tick(); expect_out("stale_pend_800", 32'h384, 1'b1, 1'b0, 1'b1);
    bus.branch_addr_i = 32'h0000_0840;
    tick(); expect_out("last_wins_hold", 32'h384, 1'b1, 1'b0, 1'b1);
    bus.stall         = 6'b0;
    bus.branch_addr_i = 32'h0000_0900;
    tick(); expect_out("live_900", 32'h900, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_out("after_live_904", 32'h904, 1'b1, 1'b0, 1'b0);
    bus.stall         = 6'b000001;
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h0000_0A00;
    tick();
    bus.branch_addr_i = 32'h0000_0A40;
    tick();
    idle_inputs();
    tick(); expect_out("last_wins_a40", 32'hA40, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_misalign();
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'hFFFF_FFFC;
    tick(); expect_out("top_fffffffc", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_out("wrap_0", 32'h0, 1'b1, 1'b0, 1'b0);
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h0000_0102;
    tick(); expect_out("misalign_102", 32'h102, 1'b1, 1'b1, 1'b0);
    idle_inputs();
    tick(); expect_out("misalign_106", 32'h106, 1'b1, 1'b1, 1'b0);
    bus.flush  = 1'b1;
    bus.new_pc = 32'h0000_0400;
    tick(); expect_out("realign_400", 32'h400, 1'b1, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bus.stall         = 6'b000001;
    bus.branch_flag_i = 1'b1;
    bus.branch_addr_i = 32'h0000_0C00;
    tick(); expect_out("pend_before_rst", 32'h400, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    expect_out("async_rst_immediate", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("async_rst_held", 32'h0, 1'b0, 1'b0, 1'b0);
    idle_inputs();
    rst = 1'b1;
    tick(); expect_out("restart_0", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("restart_4", 32'h4, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_branch_unstalled();
    test_branch_during_stall();
    test_flush_priority();
    test_live_beats_pending();
    test_wrap_misalign();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter generator for the IF stage; drives the instruction-memory address and chip enable.
- Adds a configurable reset vector and fetch stride, an exception/flush redirect, and a pending-branch latch so a branch resolved during an IF stall is never lost.
- Adds a registered fetch-misalignment flag.
- Sits between ctrl (stall/flush/new_pc), ID (branch outputs) and the instruction ROM / IF-ID register.

Parameters:
- ADDR_W, 32, width of pc and all redirect addresses.
- RESET_VECTOR, 32'h00000000, pc value while disabled and on the first enabled fetch.
- FETCH_BYTES, 4, sequential pc increment; must be a power of two, at most 2^(ADDR_W-1).
- STALL_W, 6, width of the stall vector; bit 0 controls pc.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  STALL_W  pipeline stall vector from ctrl; only bit 0 is used.
- flush  input  1  exception flush from ctrl.
- new_pc  input  ADDR_W  exception handler / eret target, valid with flush.
- branch_flag_i  input  1  taken branch/jump from ID.
- branch_addr_i  input  ADDR_W  branch target, valid with branch_flag_i.
- pc  output  ADDR_W  current fetch address.
- ce  output  1  instruction-memory chip enable.
- misalign_o  output  1  pc not aligned to FETCH_BYTES.
- branch_pend_o  output  1  a deferred branch target is held.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VECTOR, ce=0, misalign_o=0, branch_pend_o=0, pending target register cleared.
- States: DIS (ce=0) and RUN (ce=1).
  - DIS->RUN on the first clk edge with rst=1.
  - RUN->DIS only via rst.
  - In DIS, pc stays at RESET_VECTOR and stall, flush and branch inputs are ignored.
  - The first RUN cycle presents RESET_VECTOR, so latency is 1 cycle from reset release to the first valid fetch.
- Next-pc priority in RUN, evaluated at each clk edge:
  1. flush=1: pc<=new_pc. The pending branch is cleared. This applies regardless of stall[0].
  2. stall[0]=1: pc holds. If branch_flag_i=1, the pending register takes branch_addr_i and branch_pend_o<=1. A later branch during the same stall overwrites it (last wins).
  3. stall[0]=0 and branch_flag_i=1: pc<=branch_addr_i. The pending branch is cleared. A live branch beats a stale pending one.
  4. stall[0]=0 and pending set: pc<=pending target, branch_pend_o<=0.
  5. Otherwise: pc<=pc+FETCH_BYTES, truncated to ADDR_W bits.
- Arithmetic: unsigned increment; the top address wraps to 0 (for example, FFFFFFFC+4 -> 00000000) with no flag.
- misalign_o: registered alongside pc. It is 1 iff the low log2(FETCH_BYTES) bits of the next pc are non-zero. pc is loaded unmodified; no forced alignment. misalign_o=0 when FETCH_BYTES=1.
- Simultaneous flush and branch: flush wins and the branch is discarded.
- Flush during stall: the redirect is taken immediately.
- reset asserted mid-stall or while a branch is pending: everything returns to reset values asynchronously. After release, the block restarts at RESET_VECTOR.
- No combinational path from inputs to any output; all outputs are registers.

Decomposition:
- Shared defines (extend existing defines.v): ChipEnable/ChipDisable, Branch/NotBranch, NO_STOP/STOP, InstAddrBus, RESET_VECTOR default.
- Local constants: state encodings DIS/RUN, and the alignment mask derived from FETCH_BYTES.
- No sub-module. The pending-branch latch (flag plus ADDR_W register) stays inline; it is too small to justify a separate block.

Test Plan:
- Reset release: rst low for 3 cycles, then high. ce=0 and pc=00000000 during reset; ce=1 on the 1st edge after release. pc sequence is 0, 4, 8, 0C.
- Branch unstalled: at pc=00000010, branch_flag_i=1 and branch_addr_i=00000100 for 1 cycle. Next pc=00000100, then 00000104.
- Branch during stall: stall=6'b000011 for 3 cycles with pc=00000020. A branch to 00000200 arrives in the 1st stall cycle. pc holds 00000020 and branch_pend_o=1. On the first unstalled edge pc=00000200 and branch_pend_o=0.
- Flush priority: flush=1, new_pc=00000380, branch_flag_i=1 to 00000500, stall[0]=1, all in the same cycle. pc=00000380, pending cleared, then 00000384.
- Wrap and misalign (ADDR_W=32, FETCH_BYTES=4):
  - Branch to FFFFFFFC gives FFFFFFFC then 00000000, misalign_o=0.
  - Branch to 00000102 gives misalign_o=1, then pc=00000106 with misalign_o still 1.
- Async reset mid-operation: drop rst between edges while branch_pend_o=1. pc=RESET_VECTOR, ce=0 and branch_pend_o=0 immediately, without waiting for clk.
